// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed 4-digit display scanner with tear-free frame-synchronous value update
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   reset        synchronous active-high reset
//   value_in     four packed nibbles to display, digit 0 in bits [3:0]
//   load         request to display value_in (sampled whenever high)
//   digit_sel    index of the active digit, for the anode decoder
//   digit_nibble nibble of the active digit, for the segment decoder
//   digit_blank  1 when the active digit is shown dark
//   frame_tick   one-cycle pulse on the first cycle of each frame
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        load,
    output logic [1:0]  digit_sel,
    output logic [3:0]  digit_nibble,
    output logic        digit_blank,
    output logic        frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic          tick_q;
    logic          wrap, boundary;

    always_comb begin
        wrap     = cnt_q == CNT_LAST;
        boundary = wrap && sel_q == 2'd3;
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        sel_d    = wrap ? sel_q + 2'd1 : sel_q;
        // a load on the boundary cycle itself beats any older pending value
        shadow_d = !boundary ? shadow_q : load ? value_in : pend_v_q ? pend_q : shadow_q;
        pend_d   = (load && !boundary) ? value_in : pend_q;
        pend_v_d = boundary ? 1'b0 : load ? 1'b1 : pend_v_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            sel_q    <= '0;
            shadow_q <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            tick_q   <= boundary;
        end
    end

    assign digit_sel    = sel_q;
    assign digit_nibble = shadow_q[{sel_q, 2'b00} +: 4];
    assign frame_tick   = tick_q;

`ifdef LEADING_ZERO_BLANK_EN
    // dark when this digit and every more significant digit is zero; digit 0 always lit
    assign digit_blank = (sel_q != 2'd0) && ((shadow_q >> {sel_q, 2'b00}) == 16'h0000);
`else
    assign digit_blank = 1'b0;
`endif
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed self-checking bench for display_scan_ctrl with REFRESH_DIV=4
module tb_display_scan_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = '0;
    logic        load = 1'b0;
    logic [1:0]  digit_sel;
    logic [3:0]  digit_nibble;
    logic        digit_blank;
    logic        frame_tick;

    int total = 0;
    int bad = 0;
    int cyc = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZ = 1'b1;
`else
    localparam logic LZ = 1'b0;
`endif

    typedef struct {
        logic        ld;
        logic [15:0] val;
        logic [1:0]  e_sel;
        logic [3:0]  e_nib;
        logic        e_blk;
        logic        e_tick;
    } vec_t;

    vec_t tbl[48];

    display_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk(clk),
        .reset(reset),
        .value_in(value_in),
        .load(load),
        .digit_sel(digit_sel),
        .digit_nibble(digit_nibble),
        .digit_blank(digit_blank),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk(input string nm, input logic [1:0] es, input logic [3:0] en, input logic eb, input logic et);
        total++;
        if ({digit_sel, digit_nibble, digit_blank, frame_tick} !== {es, en, eb, et}) begin
            bad++;
            $display("FAIL %s cyc=%0d got sel=%0d nib=%h blk=%b tick=%b want sel=%0d nib=%h blk=%b tick=%b",
                     nm, cyc, digit_sel, digit_nibble, digit_blank, frame_tick, es, en, eb, et);
        end
    endtask

    initial begin
        // Table: entry i is driven during cycle i, expectation is for cycle i+1.
        // 1234 loaded mid frame 1, AAAA then 5555 loaded during frame 2.
        for (int i = 0; i < 48; i++) begin
            int c;
            int s;
            logic [15:0] sh;
            c = i + 1;
            s = (c / 4) % 4;
            sh = (c < 16) ? 16'h0000 : (c < 32) ? 16'h1234 : 16'h5555;
            tbl[i].ld     = (i == 5) || (i == 18) || (i == 25);
            tbl[i].val    = (i == 5) ? 16'h1234 : (i == 18) ? 16'hAAAA : (i == 25) ? 16'h5555 : 16'hDEAD;
            tbl[i].e_sel  = 2'(s);
            tbl[i].e_nib  = sh[4*s +: 4];
            tbl[i].e_blk  = LZ & (c < 16) & (s != 0);
            tbl[i].e_tick = (c % 16) == 0;
        end

        step();
        step();
        chk("reset_state", 2'd0, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc = 0;

        for (int i = 0; i < 48; i++) begin
            load = tbl[i].ld;
            value_in = tbl[i].val;
            step();
            chk("table", tbl[i].e_sel, tbl[i].e_nib, tbl[i].e_blk, tbl[i].e_tick);
        end
        load = 1'b0;

        // pending 1111, then BEEF loaded on the boundary cycle must win and clear pending
        run_to(50);
        load = 1'b1; value_in = 16'h1111;
        step();
        load = 1'b0;
        run_to(63);
        load = 1'b1; value_in = 16'hBEEF;
        step();
        load = 1'b0;
        chk("bypass_d0", 2'd0, 4'hF, 1'b0, 1'b1);
        step();
        chk("tick_single", 2'd0, 4'hF, 1'b0, 1'b0);
        run_to(68); chk("bypass_d1", 2'd1, 4'hE, 1'b0, 1'b0);
        run_to(72); chk("bypass_d2", 2'd2, 4'hE, 1'b0, 1'b0);
        run_to(76); chk("bypass_d3", 2'd3, 4'hB, 1'b0, 1'b0);
        run_to(80); chk("keep_d0", 2'd0, 4'hF, 1'b0, 1'b1);
        run_to(84); chk("keep_d1", 2'd1, 4'hE, 1'b0, 1'b0);
        run_to(92); chk("keep_d3", 2'd3, 4'hB, 1'b0, 1'b0);

        // 0070 loaded mid frame: old value held until boundary, then blanking pattern
        run_to(100);
        load = 1'b1; value_in = 16'h0070;
        step();
        load = 1'b0;
        run_to(108); chk("no_tear", 2'd3, 4'hB, 1'b0, 1'b0);
        run_to(112); chk("b70_d0", 2'd0, 4'h0, 1'b0, 1'b1);
        run_to(116); chk("b70_d1", 2'd1, 4'h7, 1'b0, 1'b0);
        run_to(120); chk("b70_d2", 2'd2, 4'h0, LZ, 1'b0);
        run_to(124); chk("b70_d3", 2'd3, 4'h0, LZ, 1'b0);
        run_to(125);
        load = 1'b1; value_in = 16'h0000;
        step();
        load = 1'b0;
        run_to(128); chk("b00_d0", 2'd0, 4'h0, 1'b0, 1'b1);
        run_to(132); chk("b00_d1", 2'd1, 4'h0, LZ, 1'b0);
        run_to(136); chk("b00_d2", 2'd2, 4'h0, LZ, 1'b0);
        run_to(140); chk("b00_d3", 2'd3, 4'h0, LZ, 1'b0);

        // reset at digit 2 with a pending load; load during reset must be ignored
        run_to(152);
        load = 1'b1; value_in = 16'h9999;
        step();
        load = 1'b0;
        chk("pend_d2", 2'd2, 4'h0, LZ, 1'b0);
        reset = 1'b1;
        load = 1'b1; value_in = 16'h7777;
        step();
        chk("mid_reset", 2'd0, 4'h0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        load = 1'b0;
        cyc = 0;
        run_to(3);  chk("rst_dwell", 2'd0, 4'h0, 1'b0, 1'b0);
        run_to(4);  chk("rst_d1", 2'd1, 4'h0, LZ, 1'b0);
        run_to(16); chk("rst_frame", 2'd0, 4'h0, 1'b0, 1'b1);
        run_to(20); chk("rst_discard", 2'd1, 4'h0, LZ, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
